// File: rtl/cnn_pkg.sv
// Shared frame geometry, streamer state encoding and a counter-width helper.
package cnn_pkg;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int ADDR_W = $clog2(IMG_W * IMG_H);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2,
        DONE   = 2'd3
    } stream_state_e;

    // Width able to hold 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_streamer_if.sv
// Frame-buffer write port, stream control and pixel stream toward the accelerator.
interface frame_streamer_if #(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int ADDR_W = cnn_pkg::ADDR_W
) ();

    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic signed [DATA_W-1:0] wr_data;
    logic                     start;
    logic                     abort;
    logic                     out_valid;
    logic signed [DATA_W-1:0] pixel_out;
    logic                     busy;
    logic                     done;

    modport master (
        output wr_en, wr_addr, wr_data, start, abort,
        input  out_valid, pixel_out, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, abort,
        output out_valid, pixel_out, busy, done
    );

endinterface

// File: rtl/frame_ram.sv
// Frame storage: one write port and a registered read port; contents are never reset.
module frame_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_streamer.sv
// Streams the stored frame in raster order through a two-stage read pipeline.
//  state  | meaning
//  IDLE   | buffer writable, waiting for start
//  STREAM | issuing row reads; after the last read, draining the pipeline
//  GAP    | LINE_GAP idle cycles between rows
//  DONE   | one-cycle frame-complete pulse
module frame_streamer #(
    parameter int DATA_W   = cnn_pkg::DATA_W,
    parameter int IMG_W    = cnn_pkg::IMG_W,
    parameter int IMG_H    = cnn_pkg::IMG_H,
    parameter int LINE_GAP = 0
) (
    input  logic            clk,
    input  logic            rst,
    frame_streamer_if.slave bus
);
    import cnn_pkg::*;

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int COL_W = cnt_w(IMG_W);
    localparam int ROW_W = cnt_w(IMG_H);
    localparam int GAP_W = cnt_w(LINE_GAP);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = (LINE_GAP > 0) ? GAP_W'(LINE_GAP - 1) : '0;

    stream_state_e            r_state;
    stream_state_e            w_next;
    logic [COL_W-1:0]         r_col;
    logic [ROW_W-1:0]         r_row;
    logic [ADDR_W-1:0]        r_addr;
    logic                     r_issued_all;
    logic [GAP_W-1:0]         r_gap_cnt;
    logic                     r_v1;
    logic                     r_last1;
    logic                     r_out_valid;
    logic                     r_out_last;
    logic signed [DATA_W-1:0] r_pixel;

    logic              w_issue;
    logic              w_row_end;
    logic              w_frame_end;
    logic              w_abort;
    logic              w_active;
    logic              w_wr_ok;
    logic [DATA_W-1:0] w_rd_data;

    assign w_active    = (r_state == STREAM) || (r_state == GAP);
    assign w_issue     = (r_state == STREAM) && !r_issued_all;
    assign w_row_end   = w_issue && (r_col == COL_LAST);
    assign w_frame_end = w_row_end && (r_row == ROW_LAST);
    assign w_abort     = bus.abort && w_active;
    assign w_wr_ok     = bus.wr_en && (r_state == IDLE) &&
                         ({1'b0, bus.wr_addr} < (ADDR_W + 1)'(NPIX));

    frame_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (NPIX),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (bus.wr_addr),
        .i_wdata (bus.wr_data),
        .i_raddr (r_addr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Frame completion is taken from the output stage so DONE follows the last visible pixel.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.start) w_next = STREAM;
            end
            STREAM: begin
                if (w_abort) begin
                    w_next = IDLE;
                end else if (r_out_last) begin
                    w_next = DONE;
                end else if (w_row_end && !w_frame_end && (LINE_GAP > 0)) begin
                    w_next = GAP;
                end
            end
            GAP: begin
                if (w_abort) begin
                    w_next = IDLE;
                end else if (r_gap_cnt == '0) begin
                    w_next = STREAM;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_addr       <= '0;
            r_issued_all <= 1'b0;
            r_gap_cnt    <= '0;
        end else if (w_abort || !w_active) begin
            r_col        <= '0;
            r_row        <= '0;
            r_addr       <= '0;
            r_issued_all <= 1'b0;
            r_gap_cnt    <= '0;
        end else begin
            if (w_issue) begin
                r_addr <= r_addr + 1'b1;
                if (w_row_end) begin
                    r_col <= '0;
                    if (w_frame_end) begin
                        r_issued_all <= 1'b1;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if ((r_state == STREAM) && (w_next == GAP)) begin
                r_gap_cnt <= GAP_LOAD;
            end else if (r_state == GAP) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1        <= 1'b0;
            r_last1     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_pixel     <= '0;
        end else if (w_abort) begin
            r_v1        <= 1'b0;
            r_last1     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_pixel     <= '0;
        end else begin
            r_v1        <= w_issue;
            r_last1     <= w_frame_end;
            r_out_valid <= r_v1;
            r_out_last  <= r_v1 && r_last1;
            r_pixel     <= r_v1 ? w_rd_data : '0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.pixel_out = r_pixel;
    assign bus.busy      = w_active;
    assign bus.done      = (r_state == DONE);

endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench: two streamers (LINE_GAP 0 and 2) share one stimulus stream.
module tb_frame_streamer;
    import cnn_pkg::*;

    localparam int NPIX = IMG_W * IMG_H;

    typedef struct {
        int                       cyc;
        logic signed [DATA_W-1:0] pix;
    } exp_t;

    logic                     clk     = 1'b0;
    logic                     rst     = 1'b0;
    logic                     wr_en   = 1'b0;
    logic [ADDR_W-1:0]        wr_addr = '0;
    logic signed [DATA_W-1:0] wr_data = '0;
    logic                     start   = 1'b0;
    logic                     abort   = 1'b0;

    frame_streamer_if bus0 ();
    frame_streamer_if bus2 ();

    assign bus0.wr_en   = wr_en;
    assign bus0.wr_addr = wr_addr;
    assign bus0.wr_data = wr_data;
    assign bus0.start   = start;
    assign bus0.abort   = abort;
    assign bus2.wr_en   = wr_en;
    assign bus2.wr_addr = wr_addr;
    assign bus2.wr_data = wr_data;
    assign bus2.start   = start;
    assign bus2.abort   = abort;

    frame_streamer #(.LINE_GAP(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    frame_streamer #(.LINE_GAP(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    logic                     ov [2];
    logic signed [DATA_W-1:0] px [2];
    logic                     bz [2];
    logic                     dn [2];

    assign ov[0] = bus0.out_valid;
    assign px[0] = bus0.pixel_out;
    assign bz[0] = bus0.busy;
    assign dn[0] = bus0.done;
    assign ov[1] = bus2.out_valid;
    assign px[1] = bus2.pixel_out;
    assign bz[1] = bus2.busy;
    assign dn[1] = bus2.done;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int lg   [2] = '{0, 2};
    int b_lo [2] = '{1, 1};
    int b_hi [2] = '{0, 0};
    int w_lo [2] = '{1, 1};
    int w_hi [2] = '{0, 0};

    logic signed [DATA_W-1:0] img [2][NPIX];
    exp_t q_pix  [2][$];
    int   q_done [2][$];

    exp_t e;
    int   ec;
    bit   exp_busy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: cyc equals the number of the rising edge that produced the sampled outputs.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (ov[d]) begin
                    if (q_pix[d].size() == 0) begin
                        errors++;
                        $display("FAIL extra_valid dut%0d cyc %0d got pixel %0d want no valid", d, cyc, px[d]);
                    end else begin
                        e = q_pix[d].pop_front();
                        if (e.cyc != cyc || e.pix !== px[d]) begin
                            errors++;
                            $display("FAIL pixel dut%0d got %0d at cyc %0d want %0d at cyc %0d",
                                     d, px[d], cyc, e.pix, e.cyc);
                        end
                    end
                end else if (px[d] !== '0) begin
                    errors++;
                    $display("FAIL idle_pixel dut%0d cyc %0d got %0d want 0", d, cyc, px[d]);
                end
                checks++;
                exp_busy = (cyc >= b_lo[d]) && (cyc <= b_hi[d]);
                if (bz[d] !== exp_busy) begin
                    errors++;
                    $display("FAIL busy dut%0d cyc %0d got %0b want %0b", d, cyc, bz[d], exp_busy);
                end
                if (dn[d] !== 1'b0) begin
                    checks++;
                    if (q_done[d].size() == 0) begin
                        errors++;
                        $display("FAIL extra_done dut%0d cyc %0d got done=%0b want 0", d, cyc, dn[d]);
                    end else begin
                        ec = q_done[d].pop_front();
                        if (ec != cyc) begin
                            errors++;
                            $display("FAIL done_cycle dut%0d got cyc %0d want cyc %0d", d, cyc, ec);
                        end
                    end
                end
            end
        end
    end

    function automatic bit accepts(input int d, input int e_n);
        return !((e_n >= w_lo[d]) && (e_n <= w_hi[d]));
    endfunction

    task automatic check_zero(input string name);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ov[d] !== 1'b0 || px[d] !== '0 || bz[d] !== 1'b0 || dn[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s dut%0d got valid=%0b pix=%0d busy=%0b done=%0b want all 0",
                         name, d, ov[d], px[d], bz[d], dn[d]);
            end
        end
    endtask

    task automatic write_px(input int addr, input int data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = DATA_W'(data);
        for (int d = 0; d < 2; d++) begin
            if (accepts(d, cyc + 1)) img[d][addr] = DATA_W'(data);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // abort_rel > 0: abort (or reset when by_rst) takes effect at edge start_edge + abort_rel.
    task automatic launch(input int abort_rel, input bit by_rst, input bit poke,
                          input bit wr, input int waddr, input int wdata);
        int   s;
        int   a;
        int   last;
        int   c;
        exp_t t;
        @(negedge clk);
        s     = cyc + 1;
        start = 1'b1;
        if (wr) begin
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(waddr);
            wr_data = DATA_W'(wdata);
        end
        for (int d = 0; d < 2; d++) begin
            if (wr && accepts(d, s)) img[d][waddr] = DATA_W'(wdata);
            last = s + 2 + (NPIX - 1) + (IMG_H - 1) * lg[d];
            a    = (abort_rel > 0) ? s + abort_rel : last + 100;
            for (int k = 0; k < NPIX; k++) begin
                c = s + 2 + k + (k / IMG_W) * lg[d];
                if (c < a) begin
                    t.cyc = c;
                    t.pix = img[d][k];
                    q_pix[d].push_back(t);
                end
            end
            if (a > last + 1) q_done[d].push_back(last + 1);
            b_lo[d] = s;
            b_hi[d] = (a - 1 < last) ? a - 1 : last;
            w_lo[d] = s + 1;
            w_hi[d] = (a <= last + 1) ? a : last + 2;
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        if (poke) begin
            while (cyc < s + 29) @(negedge clk);
            start   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(5);
            wr_data = DATA_W'(99);
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
        end
        if (abort_rel > 0) begin
            while (cyc < s + abort_rel - 1) @(negedge clk);
            if (by_rst) begin
                rst = 1'b1;
                #1;
                check_zero("async_reset");
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
            end else begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
            end
        end
        while (cyc < s + 2 + NPIX + (IMG_H - 1) * 2 + 4) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (q_pix[d].size() != 0 || q_done[d].size() != 0) begin
                errors++;
                $display("FAIL frame_drain dut%0d got %0d pixels and %0d dones outstanding want 0",
                         d, q_pix[d].size(), q_done[d].size());
                q_pix[d].delete();
                q_done[d].delete();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc %0d got no finish want finish", cyc);
        $fatal(1);
    end

    initial begin
        #2 rst = 1'b1;
        #1;
        check_zero("reset_hold");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset_release");

        for (int k = 0; k < NPIX; k++) write_px(k, k);

        launch(0, 1'b0, 1'b0, 1'b0, 0, 0);      // full frame, contiguous and gapped
        launch(23, 1'b0, 1'b0, 1'b0, 0, 0);     // abort while dut0 shows pixel 20
        launch(0, 1'b0, 1'b0, 1'b0, 0, 0);      // restarts from pixel 0
        launch(0, 1'b0, 1'b1, 1'b0, 0, 0);      // start + write(5,99) while busy
        launch(0, 1'b0, 1'b0, 1'b0, 0, 0);      // pixel 5 still 5
        launch(30, 1'b1, 1'b0, 1'b0, 0, 0);     // reset mid-frame
        launch(0, 1'b0, 1'b0, 1'b0, 0, 0);      // stored frame unchanged
        launch(0, 1'b0, 1'b0, 1'b1, 10, 55);    // write and start on one edge
        write_px(0, -128);
        write_px(NPIX - 1, -1);
        launch(0, 1'b0, 1'b0, 1'b0, 0, 0);      // signed extremes

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
